// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract unit.
// Each RUN cycle adds STEP bits of the latched operands, starting with the
// least significant slice. The carry is held in a register between slices.
// Operands, mode and carry-in are captured when start is accepted in IDLE.
// sum/cout/ovf update together with a one-cycle done pulse.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Slice datapath signals.
  logic [STEP:0]    sliceFull;
  logic [STEP-1:0]  sliceSum;
  logic             sliceCout;
  logic             carryIntoTop;
  logic [WIDTH-1:0] sliceWide;
  logic [WIDTH-1:0] accNext;
  logic             lastSlice;

  assign lastSlice = (cnt_q == CW'(N - 1));

  // Add the lowest STEP bits of the shifting operands plus the held carry,
  // and build the next value of the result shift register.
  always_comb begin
    sliceFull    = {1'b0, opA_q[STEP-1:0]} + {1'b0, opB_q[STEP-1:0]}
                 + {{STEP{1'b0}}, carry_q};
    sliceSum     = sliceFull[STEP-1:0];
    sliceCout    = sliceFull[STEP];
    // Carry into the slice's top bit is recovered from its sum bit; in the
    // final slice this is the carry into bit WIDTH-1.
    carryIntoTop = sliceSum[STEP-1] ^ opA_q[STEP-1] ^ opB_q[STEP-1];
    sliceWide    = '0;
    sliceWide[STEP-1:0] = sliceSum;
    // New result bits enter at the top, so after N slices the first slice
    // has reached the bottom of the register.
    accNext      = (acc_q >> STEP) | (sliceWide << (WIDTH - STEP));
  end

  // Next-state logic: accept a request in IDLE, step one slice per cycle in
  // RUN, and publish the result on the final slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          // Subtraction is a + ~b + 1, so b is inverted and the carry seeded.
          opB_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        opA_d   = opA_q >> STEP;
        opB_d   = opB_q >> STEP;
        acc_d   = accNext;
        carry_d = sliceCout;
        cnt_d   = cnt_q + CW'(1);
        if (lastSlice) begin
          sum_d   = accNext;
          cout_d  = sliceCout;
          ovf_d   = carryIntoTop ^ sliceCout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub.
// Three instances (STEP = 1, 4, 8) share operand inputs, and each has its own
// start signal. Expected results are queued when stimulus is issued and are
// popped by a monitor whenever an instance raises done.
module tb_serial_addsub;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      startV;
  logic            sub;
  logic            cin;
  logic [7:0]      a;
  logic [7:0]      b;
  logic [2:0][7:0] sumV;
  logic [2:0]      coutV;
  logic [2:0]      ovfV;
  logic [2:0]      busyV;
  logic [2:0]      doneV;
  logic [2:0]      prevDone = 3'b000;

  int nChecks = 0;
  int nFail   = 0;

  logic [9:0] expQ0[$];
  logic [9:0] expQ1[$];
  logic [9:0] expQ2[$];

  // Hand-computed vectors: {sub, cin, a, b, sum, cout, ovf}
  logic       vSub  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       vCin  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] vA    [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
  logic [7:0] vB    [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
  logic [7:0] vSum  [4] = '{8'h80, 8'h01, 8'hFE, 8'h7F};
  logic       vCout [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       vOvf  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Clock generation.
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(startV[0]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sumV[0]), .cout(coutV[0]), .ovf(ovfV[0]),
    .busy(busyV[0]), .done(doneV[0])
  );

  serial_addsub #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(startV[1]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sumV[1]), .cout(coutV[1]), .ovf(ovfV[1]),
    .busy(busyV[1]), .done(doneV[1])
  );

  serial_addsub #(.WIDTH(8), .STEP(8)) dut8 (
    .clk(clk), .reset(reset), .start(startV[2]), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sumV[2]), .cout(coutV[2]), .ovf(ovfV[2]),
    .busy(busyV[2]), .done(doneV[2])
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int idx, input logic [9:0] v);
    case (idx)
      0:       expQ0.push_back(v);
      1:       expQ1.push_back(v);
      default: expQ2.push_back(v);
    endcase
  endtask

  // Drive one request (called at a negedge) and queue its expected result.
  task automatic applyStimulus(input int idx, input logic s, input logic c,
                               input logic [7:0] aa, input logic [7:0] bb,
                               input logic [7:0] eSum, input logic eC,
                               input logic eV, input bit expectDone);
    sub         = s;
    cin         = c;
    a           = aa;
    b           = bb;
    startV[idx] = 1'b1;
    if (expectDone) pushExp(idx, {eSum, eC, eV});
  endtask

  // Wait (bounded) for done, checking latency, busy continuity and, when
  // requested, that sum holds the previous result during the run. An ignored
  // start with other operands can be injected at cycle injectAt.
  task automatic waitDone(input int idx, input int lat, input int injectAt,
                          input bit holdEn, input logic [7:0] holdVal);
    int cyc    = 0;
    bit busyOk = 1'b1;
    bit holdOk = 1'b1;
    @(negedge clk);
    startV[idx] = 1'b0;
    while (!doneV[idx] && cyc <= 40) begin
      if (!busyV[idx]) busyOk = 1'b0;
      if (holdEn && sumV[idx] !== holdVal) holdOk = 1'b0;
      if (cyc == injectAt) begin
        startV[idx] = 1'b1;
        sub = 1'b1;
        cin = 1'b1;
        a   = 8'h33;
        b   = 8'h11;
      end else begin
        startV[idx] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    startV[idx] = 1'b0;
    checkOutput($sformatf("latency_dut%0d", idx), cyc, lat);
    checkOutput($sformatf("busyDuringRun_dut%0d", idx), {31'd0, busyOk}, 1);
    checkOutput($sformatf("busyLowAtDone_dut%0d", idx), {31'd0, busyV[idx]}, 0);
    if (holdEn) checkOutput($sformatf("sumHeld_dut%0d", idx), {31'd0, holdOk}, 1);
  endtask

  // Monitor: compare every done against the head of that instance's queue.
  always @(negedge clk) begin
    logic [9:0] e;
    bit         have;
    for (int i = 0; i < 3; i++) begin
      if (doneV[i]) begin
        have = 1'b0;
        e    = '0;
        case (i)
          0: if (expQ0.size() > 0) begin e = expQ0.pop_front(); have = 1'b1; end
          1: if (expQ1.size() > 0) begin e = expQ1.pop_front(); have = 1'b1; end
          default: if (expQ2.size() > 0) begin e = expQ2.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
          checkOutput($sformatf("sum_dut%0d", i), {24'd0, sumV[i]}, {24'd0, e[9:2]});
          checkOutput($sformatf("cout_dut%0d", i), {31'd0, coutV[i]}, {31'd0, e[1]});
          checkOutput($sformatf("ovf_dut%0d", i), {31'd0, ovfV[i]}, {31'd0, e[0]});
        end else begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpectedDone_dut%0d: got done=1, expected no pending result", i);
        end
        if (i < 2) checkOutput($sformatf("donePulse_dut%0d", i), {31'd0, prevDone[i]}, 0);
      end
    end
    prevDone = doneV;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    reset  = 1'b1;
    startV = 3'b000;
    sub    = 1'b0;
    cin    = 1'b0;
    a      = 8'h00;
    b      = 8'h00;

    // Start held during reset must not be accepted.
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("busyInReset", {31'd0, busyV[0]}, 0);
      checkOutput("doneInReset", {31'd0, doneV[0]}, 0);
    end
    reset  = 1'b0;
    startV = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("resetSum_dut%0d", i), {24'd0, sumV[i]}, 0);
      checkOutput($sformatf("resetCout_dut%0d", i), {31'd0, coutV[i]}, 0);
      checkOutput($sformatf("resetOvf_dut%0d", i), {31'd0, ovfV[i]}, 0);
      checkOutput($sformatf("resetBusy_dut%0d", i), {31'd0, busyV[i]}, 0);
      checkOutput($sformatf("resetDone_dut%0d", i), {31'd0, doneV[i]}, 0);
    end

    // Directed add/subtract vectors, STEP=1.
    $display("[TB] STEP=1 vectors");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(0, vSub[v], vCin[v], vA[v], vB[v], vSum[v], vCout[v], vOvf[v], 1'b1);
      waitDone(0, 8, -1, 1'b0, 8'h00);
    end

    // Start pulsed mid-run with other operands must be ignored.
    $display("[TB] ignored start while busy");
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    waitDone(0, 8, 2, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("noQueuedStart", {31'd0, busyV[0]}, 0);

    // Back-to-back: second request issued in the done cycle.
    $display("[TB] back-to-back");
    applyStimulus(0, 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1);
    waitDone(0, 8, -1, 1'b0, 8'h00);
    applyStimulus(0, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
    waitDone(0, 8, -1, 1'b1, 8'hFE);

    // Reset mid-run aborts the operation and clears the outputs.
    $display("[TB] reset mid-run");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortSum", {24'd0, sumV[0]}, 0);
    checkOutput("abortCout", {31'd0, coutV[0]}, 0);
    checkOutput("abortOvf", {31'd0, ovfV[0]}, 0);
    checkOutput("abortBusy", {31'd0, busyV[0]}, 0);
    checkOutput("abortDone", {31'd0, doneV[0]}, 0);
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1);
    waitDone(0, 8, -1, 1'b0, 8'h00);

    // Same vectors with STEP=4 (latency 2) and STEP=8 (latency 1).
    $display("[TB] STEP=4 and STEP=8 vectors");
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      applyStimulus(1, vSub[v], vCin[v], vA[v], vB[v], vSum[v], vCout[v], vOvf[v], 1'b1);
      waitDone(1, 2, -1, 1'b0, 8'h00);
      @(negedge clk);
      applyStimulus(2, vSub[v], vCin[v], vA[v], vB[v], vSum[v], vCout[v], vOvf[v], 1'b1);
      waitDone(2, 1, -1, 1'b0, 8'h00);
    end

    repeat (5) @(negedge clk);
    checkOutput("queuesDrained", expQ0.size() + expQ1.size() + expQ2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
